// File: rtl/bsg_gateway_power_seq_pkg.sv
// Shared types for the gateway power sequencer: state encoding and the
// per-state output decode that drives rails, clock resets and link reset.
package bsg_gateway_power_seq_pkg;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        UP_IO    = 4'd1,
        UP_CORE  = 4'd2,
        UP_PLL   = 4'd3,
        CLK_RST  = 4'd4,
        TAG      = 4'd5,
        LINK_RST = 4'd6,
        CALIB    = 4'd7,
        RUN      = 4'd8,
        DN_CLK   = 4'd9,
        DN_PLL   = 4'd10,
        DN_CORE  = 4'd11,
        DN_IO    = 4'd12
    } state_e;

    typedef struct packed {
        logic io_en;
        logic core_en;
        logic pll_en;
        logic clk_reset;
        logic link_reset;
        logic ready;
    } seq_out_t;

    // Rails are cumulative ranges over the enum ordering, so the encoding
    // order above must not change.
    function automatic seq_out_t decode_outputs(input state_e s);
        seq_out_t o;
        o            = '0;
        o.io_en      = (s >= UP_IO)   && (s <= DN_PLL);
        o.core_en    = (s >= UP_CORE) && (s <= DN_CLK);
        o.pll_en     = (s >= UP_PLL)  && (s <= DN_CLK);
        o.clk_reset  = !((s == TAG) || (s == LINK_RST) || (s == CALIB) || (s == RUN));
        o.link_reset = !((s == CALIB) || (s == RUN));
        o.ready      = (s == RUN);
        return o;
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/bsg_gateway_seq_timer.sv
// Loadable down-counter that saturates at zero; zero flags the last cycle
// of a dwell or timeout window.
module bsg_gateway_seq_timer #(
    parameter int unsigned width_p = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [width_p-1:0] load_value,
    output logic               zero
);

    logic [width_p-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - width_p'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/bsg_gateway_power_seq.sv
// Gateway bring-up/shutdown sequencer: ordered rail enables, clock resets,
// tag programming and comm-link reset with dwell times and timeouts.
module bsg_gateway_power_seq
    import bsg_gateway_power_seq_pkg::*;
#(
    parameter int unsigned step_cycles_p   = 1024,
    parameter int unsigned tag_timeout_p   = 65536,
    parameter int unsigned calib_timeout_p = 1048576,
    parameter int unsigned num_clk_p       = 6
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic                 start_i,
    input  logic                 tag_done_i,
    input  logic                 calib_done_i,
    output logic                 io_en_o,
    output logic                 core_en_o,
    output logic                 pll_en_o,
    output logic [num_clk_p-1:0] clk_reset_o,
    output logic                 tag_start_o,
    output logic                 link_reset_o,
    output logic                 ready_o,
    output logic                 error_o,
    output logic [3:0]           state_o
);

    localparam int unsigned max_limit =
        max_u(max_u(step_cycles_p, tag_timeout_p), calib_timeout_p);
    localparam int unsigned cnt_width = (max_limit > 1) ? $clog2(max_limit) : 1;

    state_e               state;
    state_e               next_state;
    logic                 arm;
    logic                 set_error;
    logic                 load;
    logic                 zero;
    logic [cnt_width-1:0] load_value;
    seq_out_t             next_out;

    always_comb begin
        next_state = state;
        set_error  = 1'b0;
        case (state)
            IDLE:     if (start_i && arm) next_state = UP_IO;
            UP_IO:    if (!start_i) next_state = DN_CLK; else if (zero) next_state = UP_CORE;
            UP_CORE:  if (!start_i) next_state = DN_CLK; else if (zero) next_state = UP_PLL;
            UP_PLL:   if (!start_i) next_state = DN_CLK; else if (zero) next_state = CLK_RST;
            CLK_RST:  if (!start_i) next_state = DN_CLK; else if (zero) next_state = TAG;
            // tag_start_o is high exactly in the first TAG cycle, so it
            // doubles as the "ignore tag_done_i" qualifier.
            TAG: begin
                if (!start_i) begin
                    next_state = DN_CLK;
                end else if (zero) begin
                    next_state = DN_CLK;
                    set_error  = 1'b1;
                end else if (tag_done_i && !tag_start_o) begin
                    next_state = LINK_RST;
                end
            end
            LINK_RST: if (!start_i) next_state = DN_CLK; else if (zero) next_state = CALIB;
            CALIB: begin
                if (!start_i) begin
                    next_state = DN_CLK;
                end else if (zero) begin
                    next_state = DN_CLK;
                    set_error  = 1'b1;
                end else if (calib_done_i) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (!start_i) begin
                    next_state = DN_CLK;
                end else if (!calib_done_i) begin
                    next_state = DN_CLK;
                    set_error  = 1'b1;
                end
            end
            DN_CLK:   if (zero) next_state = DN_PLL;
            DN_PLL:   if (zero) next_state = DN_CORE;
            DN_CORE:  if (zero) next_state = DN_IO;
            DN_IO:    if (zero) next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    always_comb begin
        load_value = '0;
        case (next_state)
            TAG:     load_value = cnt_width'(tag_timeout_p - 1);
            CALIB:   load_value = cnt_width'(calib_timeout_p - 1);
            IDLE,
            RUN:     load_value = '0;
            default: load_value = cnt_width'(step_cycles_p - 1);
        endcase
    end

    assign load = (next_state != state);

    bsg_gateway_seq_timer #(
        .width_p(cnt_width)
    ) timer (
        .clk       (clk_i),
        .rst_n     (reset_n_i),
        .load      (load),
        .load_value(load_value),
        .zero      (zero)
    );

    assign next_out = decode_outputs(next_state);

    // Outputs are decoded from next_state so they change on the same edge
    // as the state register rather than one cycle later.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state        <= IDLE;
            arm          <= 1'b0;
            io_en_o      <= 1'b0;
            core_en_o    <= 1'b0;
            pll_en_o     <= 1'b0;
            clk_reset_o  <= '1;
            tag_start_o  <= 1'b0;
            link_reset_o <= 1'b1;
            ready_o      <= 1'b0;
            error_o      <= 1'b0;
        end else begin
            state        <= next_state;
            arm          <= (state == IDLE) && (next_state == IDLE) && (arm || !start_i);
            io_en_o      <= next_out.io_en;
            core_en_o    <= next_out.core_en;
            pll_en_o     <= next_out.pll_en;
            clk_reset_o  <= {num_clk_p{next_out.clk_reset}};
            tag_start_o  <= (next_state == TAG) && (state != TAG);
            link_reset_o <= next_out.link_reset;
            ready_o      <= next_out.ready;
            if ((state == IDLE) && (next_state == UP_IO)) begin
                error_o <= 1'b0;
            end else if (set_error) begin
                error_o <= 1'b1;
            end
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_bsg_gateway_power_seq.sv
// Directed bench for bsg_gateway_power_seq: expected per-cycle output
// snapshots are queued as stimulus is driven and checked when due.
module tb_bsg_gateway_power_seq;

    localparam logic [3:0] S_IDLE = 4'd0, S_UP_IO = 4'd1, S_UP_CORE = 4'd2, S_UP_PLL = 4'd3;
    localparam logic [3:0] S_CLK_RST = 4'd4, S_TAG = 4'd5, S_LINK_RST = 4'd6, S_CALIB = 4'd7;
    localparam logic [3:0] S_RUN = 4'd8, S_DN_CLK = 4'd9, S_DN_PLL = 4'd10, S_DN_CORE = 4'd11;
    localparam logic [3:0] S_DN_IO = 4'd12;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b1;
    logic       tag_done = 1'b0;
    logic       calib_done = 1'b0;
    logic       io_en, core_en, pll_en, tag_start, link_reset, ready, error;
    logic [5:0] clk_reset;
    logic [3:0] state_o;

    bsg_gateway_power_seq #(
        .step_cycles_p  (4),
        .tag_timeout_p  (16),
        .calib_timeout_p(32),
        .num_clk_p      (6)
    ) dut (
        .clk_i       (clk),
        .reset_n_i   (rst_n),
        .start_i     (start),
        .tag_done_i  (tag_done),
        .calib_done_i(calib_done),
        .io_en_o     (io_en),
        .core_en_o   (core_en),
        .pll_en_o    (pll_en),
        .clk_reset_o (clk_reset),
        .tag_start_o (tag_start),
        .link_reset_o(link_reset),
        .ready_o     (ready),
        .error_o     (error),
        .state_o     (state_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        int         id;
        logic [3:0] st;
        bit         err;
        bit         ts;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   cyc = 0;
    int   nid = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Reference outputs per state, written from the rail/reset table.
    task automatic cmp(input exp_t e);
        logic       x_io, x_core, x_pll, x_link, x_rdy;
        logic [5:0] x_clkr;
        x_io   = (e.st >= 4'd1) && (e.st <= 4'd10);
        x_core = (e.st >= 4'd2) && (e.st <= 4'd9);
        x_pll  = (e.st >= 4'd3) && (e.st <= 4'd9);
        x_clkr = ((e.st >= 4'd5) && (e.st <= 4'd8)) ? 6'h00 : 6'h3f;
        x_link = !((e.st == 4'd7) || (e.st == 4'd8));
        x_rdy  = (e.st == 4'd8);
        chk($sformatf("e%0d_state", e.id), {4'b0, state_o}, {4'b0, e.st});
        chk($sformatf("e%0d_io_en", e.id), {7'b0, io_en}, {7'b0, x_io});
        chk($sformatf("e%0d_core_en", e.id), {7'b0, core_en}, {7'b0, x_core});
        chk($sformatf("e%0d_pll_en", e.id), {7'b0, pll_en}, {7'b0, x_pll});
        chk($sformatf("e%0d_clk_reset", e.id), {2'b0, clk_reset}, {2'b0, x_clkr});
        chk($sformatf("e%0d_link_reset", e.id), {7'b0, link_reset}, {7'b0, x_link});
        chk($sformatf("e%0d_ready", e.id), {7'b0, ready}, {7'b0, x_rdy});
        chk($sformatf("e%0d_tag_start", e.id), {7'b0, tag_start}, {7'b0, e.ts});
        chk($sformatf("e%0d_error", e.id), {7'b0, error}, {7'b0, e.err});
    endtask

    task automatic expect_at(input int d, input logic [3:0] st, input bit err, input bit ts);
        exp_t e;
        int   i;
        e.cyc = cyc + d;
        e.id  = nid++;
        e.st  = st;
        e.err = err;
        e.ts  = ts;
        i = 0;
        while (i < sb.size() && sb[i].cyc <= e.cyc) i++;
        sb.insert(i, e);
    endtask

    task automatic check_now(input logic [3:0] st, input bit err);
        exp_t e;
        e.cyc = cyc;
        e.id  = nid++;
        e.st  = st;
        e.err = err;
        e.ts  = 1'b0;
        cmp(e);
    endtask

    task automatic go_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (cyc > 2000) begin
            $display("FAIL watchdog cycles=%0d limit=2000", cyc);
            $fatal(1, "watchdog expired");
        end
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            cur = sb.pop_front();
            cmp(cur);
        end
    end

    initial begin
        int n;
        int m;

        // Reset with start already high: must wait for a 0 then 1.
        repeat (3) @(negedge clk);
        check_now(S_IDLE, 0);
        rst_n = 1'b1;
        n = cyc;
        expect_at(1, S_IDLE, 0, 0);
        expect_at(5, S_IDLE, 0, 0);
        go_to(n + 5);
        start = 1'b0;
        @(negedge clk);

        // Full power-up to RUN.
        n = cyc;
        start = 1'b1;
        expect_at(1, S_UP_IO, 0, 0);
        expect_at(4, S_UP_IO, 0, 0);
        expect_at(5, S_UP_CORE, 0, 0);
        expect_at(8, S_UP_CORE, 0, 0);
        expect_at(9, S_UP_PLL, 0, 0);
        expect_at(13, S_CLK_RST, 0, 0);
        expect_at(16, S_CLK_RST, 0, 0);
        expect_at(17, S_TAG, 0, 1);
        expect_at(18, S_TAG, 0, 0);
        expect_at(21, S_TAG, 0, 0);
        expect_at(22, S_LINK_RST, 0, 0);
        expect_at(25, S_LINK_RST, 0, 0);
        expect_at(26, S_CALIB, 0, 0);
        expect_at(35, S_CALIB, 0, 0);
        expect_at(36, S_RUN, 0, 0);
        expect_at(40, S_RUN, 0, 0);
        go_to(n + 21);
        tag_done = 1'b1;
        go_to(n + 22);
        tag_done = 1'b0;
        go_to(n + 35);
        calib_done = 1'b1;
        go_to(n + 40);

        // Orderly power-down from RUN; start raised mid-shutdown is ignored.
        n = cyc;
        start = 1'b0;
        expect_at(1, S_DN_CLK, 0, 0);
        expect_at(4, S_DN_CLK, 0, 0);
        expect_at(5, S_DN_PLL, 0, 0);
        expect_at(8, S_DN_PLL, 0, 0);
        expect_at(9, S_DN_CORE, 0, 0);
        expect_at(13, S_DN_IO, 0, 0);
        expect_at(16, S_DN_IO, 0, 0);
        expect_at(17, S_IDLE, 0, 0);
        expect_at(19, S_IDLE, 0, 0);
        go_to(n + 6);
        start = 1'b1;
        go_to(n + 19);
        calib_done = 1'b0;
        start = 1'b0;
        @(negedge clk);

        // Tag never completes: timeout 16 cycles into TAG, then shutdown.
        n = cyc;
        start = 1'b1;
        expect_at(1, S_UP_IO, 0, 0);
        expect_at(17, S_TAG, 0, 1);
        expect_at(32, S_TAG, 0, 0);
        expect_at(33, S_DN_CLK, 1, 0);
        expect_at(36, S_DN_CLK, 1, 0);
        expect_at(37, S_DN_PLL, 1, 0);
        expect_at(40, S_DN_PLL, 1, 0);
        expect_at(41, S_DN_CORE, 1, 0);
        expect_at(45, S_DN_IO, 1, 0);
        expect_at(49, S_IDLE, 1, 0);
        expect_at(55, S_IDLE, 1, 0);
        go_to(n + 55);
        start = 1'b0;
        @(negedge clk);

        // Restart clears error; tag_done held early is ignored in first TAG
        // cycle; calib_done dropping in RUN raises error.
        n = cyc;
        start = 1'b1;
        expect_at(1, S_UP_IO, 0, 0);
        expect_at(17, S_TAG, 0, 1);
        expect_at(18, S_TAG, 0, 0);
        expect_at(19, S_LINK_RST, 0, 0);
        expect_at(23, S_CALIB, 0, 0);
        expect_at(32, S_CALIB, 0, 0);
        expect_at(33, S_RUN, 0, 0);
        expect_at(35, S_RUN, 0, 0);
        expect_at(36, S_DN_CLK, 1, 0);
        expect_at(40, S_DN_PLL, 1, 0);
        expect_at(52, S_IDLE, 1, 0);
        go_to(n + 15);
        tag_done = 1'b1;
        go_to(n + 19);
        tag_done = 1'b0;
        go_to(n + 32);
        calib_done = 1'b1;
        go_to(n + 35);
        calib_done = 1'b0;
        go_to(n + 52);
        start = 1'b0;
        @(negedge clk);

        // Asynchronous reset while in UP_PLL.
        n = cyc;
        start = 1'b1;
        expect_at(1, S_UP_IO, 0, 0);
        expect_at(9, S_UP_PLL, 0, 0);
        expect_at(10, S_UP_PLL, 0, 0);
        go_to(n + 10);
        #2;
        rst_n = 1'b0;
        #1;
        check_now(S_IDLE, 0);
        expect_at(1, S_IDLE, 0, 0);
        go_to(n + 12);
        rst_n = 1'b1;
        expect_at(2, S_IDLE, 0, 0);
        go_to(n + 15);

        for (int i = 0; i < 50 && sb.size() > 0; i++) @(negedge clk);
        chk("sb_drain", 8'(sb.size()), 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
